// File: rtl/alu_cmd_driver.sv
// Buffers ALU commands in a FIFO, drives one at a time into the ALU and returns each result.
// Define ALU_CMD_DRIVER_OPCOUNT_EN to build the saturating completed-operation counter.
module alu_cmd_driver #(
    parameter int unsigned WIDTH   = 40,
    parameter int unsigned SEL_W   = 5,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [SEL_W-1:0] req_s,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_s,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [SEL_W-1:0] rsp_s,
    output logic             busy,
    output logic [15:0]      op_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(ALU_LAT + 1);
    localparam int unsigned EW = 2 * WIDTH + SEL_W;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             full, empty, push, pop;
    logic [EW-1:0]    head;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [SEL_W-1:0] alu_s_q, alu_s_d, rsp_s_q, rsp_s_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = req_valid && !full;
    assign head  = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {req_a, req_b, req_s};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            rsp_s_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_s_q     <= alu_s_d;
            rsp_s_q     <= rsp_s_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_s_d     = alu_s_q;
        rsp_s_d     = rsp_s_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    alu_a_d = head[EW-1 -: WIDTH];
                    alu_b_d = head[SEL_W +: WIDTH];
                    alu_s_d = head[SEL_W-1:0];
                    rsp_s_d = head[SEL_W-1:0];
                    cnt_d   = CW'(ALU_LAT);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == CW'(1)) begin
                    rsp_data_d  = alu_out;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready = !full;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_s     = rsp_s_q;
    assign busy      = (state_q != StIdle) || !empty;

`ifdef ALU_CMD_DRIVER_OPCOUNT_EN
    logic [15:0] op_count_q;
    logic        done;

    assign done = (state_q == StResp) && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else if (done && (op_count_q != 16'hFFFF)) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = 16'h0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: one ALU_LAT=2 instance plus an ALU_LAT=1 instance
// for the short-latency single-command case.
module tb_alu_cmd_driver;

    localparam int NV = 11;

`ifdef ALU_CMD_DRIVER_OPCOUNT_EN
    localparam bit OPC = 1'b1;
`else
    localparam bit OPC = 1'b0;
`endif

    typedef struct {
        logic [39:0] a;
        logic [39:0] b;
        logic [4:0]  s;
        logic [39:0] exp;
    } vec_t;

    vec_t tbl [NV];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [39:0] req_a = '0;
    logic [39:0] req_b = '0;
    logic [4:0]  req_s = '0;
    logic        rsp_ready = 1'b0;

    logic        req_ready0, rsp_valid0, busy0;
    logic [39:0] alu_a0, alu_b0, alu_out0, rsp_data0;
    logic [4:0]  alu_s0, rsp_s0;
    logic [15:0] op_count0;

    logic        req_ready1, rsp_valid1, busy1;
    logic [39:0] alu_a1, alu_b1, alu_out1, rsp_data1;
    logic [4:0]  alu_s1, rsp_s1;
    logic [15:0] op_count1;

    int total = 0;
    int bad = 0;
    int next_rsp = 0;
    bit saw_full = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [39:0] alu_f(input logic [39:0] a, input logic [39:0] b,
                                          input logic [4:0] s);
        return (s == 5'b00101) ? a + b : a ^ b;
    endfunction

    always_ff @(posedge clk) alu_out0 <= alu_f(alu_a0, alu_b0, alu_s0);
    // A one-edge latency leaves no room for a stub register.
    assign alu_out1 = alu_f(alu_a1, alu_b1, alu_s1);

    alu_cmd_driver #(.WIDTH(40), .SEL_W(5), .DEPTH(4), .ALU_LAT(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
        .req_a(req_a), .req_b(req_b), .req_s(req_s),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_s(alu_s0), .alu_out(alu_out0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_data(rsp_data0),
        .rsp_s(rsp_s0), .busy(busy0), .op_count(op_count0)
    );

    alu_cmd_driver #(.WIDTH(40), .SEL_W(5), .DEPTH(4), .ALU_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
        .req_a(req_a), .req_b(req_b), .req_s(req_s),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_s(alu_s1), .alu_out(alu_out1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1),
        .rsp_s(rsp_s1), .busy(busy1), .op_count(op_count1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called once per negedge; a response seen with rsp_ready high is taken on the next edge.
    task automatic collect();
        if (rsp_valid0 && rsp_ready) begin
            if (next_rsp < NV) begin
                check($sformatf("rsp%0d_data", next_rsp), 64'(rsp_data0), 64'(tbl[next_rsp].exp));
                check($sformatf("rsp%0d_s", next_rsp), 64'(rsp_s0), 64'(tbl[next_rsp].s));
            end else begin
                check("extra_rsp", 64'(next_rsp), 64'(NV - 1));
            end
            next_rsp++;
        end
    endtask

    task automatic push_all(input int first, input int cnt);
        int idx = first;
        int cyc = 0;
        bit will_push;
        while (idx < first + cnt && cyc < 100) begin
            @(negedge clk);
            collect();
            if (!req_ready0) saw_full = 1'b1;
            req_valid = 1'b1;
            req_a = tbl[idx].a;
            req_b = tbl[idx].b;
            req_s = tbl[idx].s;
            will_push = req_ready0;
            @(posedge clk);
            if (will_push) idx++;
            cyc++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        collect();
        if (!req_ready0) saw_full = 1'b1;
        check("push_done", 64'(idx), 64'(first + cnt));
    endtask

    task automatic drain(input int upto);
        int cyc = 0;
        while (next_rsp < upto && cyc < 200) begin
            @(negedge clk);
            collect();
            cyc++;
        end
        check("drain_count", 64'(next_rsp), 64'(upto));
    endtask

    initial begin
        int edges;
        int e1;
        logic [39:0] d1;
        logic [4:0]  s1v;
        bit seen;

        tbl[0]  = '{40'h000000000B, 40'h0000000003, 5'b00101, 40'h000000000E};
        tbl[1]  = '{40'hFF00FF00FF, 40'h0F0F0F0F0F, 5'b00111, 40'hF00FF00FF0};
        tbl[2]  = '{40'h123456789A, 40'h0000000001, 5'b00110, 40'h123456789B};
        tbl[3]  = '{40'hAAAAAAAAAA, 40'h5555555555, 5'b01000, 40'hFFFFFFFFFF};
        tbl[4]  = '{40'h0000000000, 40'hDEADBEEF00, 5'b01011, 40'hDEADBEEF00};
        tbl[5]  = '{40'hFFFFFFFFFF, 40'h0000000001, 5'b01100, 40'hFFFFFFFFFE};
        tbl[6]  = '{40'hFFFFFFFFFF, 40'h0000000002, 5'b00101, 40'h0000000001};
        tbl[7]  = '{40'h8000000000, 40'h8000000000, 5'b00101, 40'h0000000000};
        tbl[8]  = '{40'h0000000010, 40'h0000000011, 5'b00000, 40'h0000000001};
        tbl[9]  = '{40'h0123456789, 40'h0000000000, 5'b11111, 40'h0123456789};
        tbl[10] = '{40'h0000000007, 40'h0000000008, 5'b00101, 40'h000000000F};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_rsp_valid", 64'(rsp_valid0), 64'(0));
        check("rst_alu_a", 64'(alu_a0), 64'(0));
        check("rst_alu_b", 64'(alu_b0), 64'(0));
        check("rst_alu_s", 64'(alu_s0), 64'(0));
        check("rst_rsp_data", 64'(rsp_data0), 64'(0));
        check("rst_rsp_s", 64'(rsp_s0), 64'(0));
        check("rst_req_ready", 64'(req_ready0), 64'(1));
        check("rst_busy", 64'(busy0), 64'(0));
        check("rst_op_count", 64'(op_count0), 64'(0));

        // Single command; the push edge counts as edge 1
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_a = tbl[0].a;
        req_b = tbl[0].b;
        req_s = tbl[0].s;
        edges = 0;
        e1 = 0;
        d1 = '0;
        s1v = '0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid1 && e1 == 0) begin
                e1 = edges;
                d1 = rsp_data1;
                s1v = rsp_s1;
            end
        end while (!rsp_valid0 && edges < 20);
        check("single_latency", 64'(edges), 64'(4));
        check("single_data", 64'(rsp_data0), 64'(tbl[0].exp));
        check("single_s", 64'(rsp_s0), 64'(tbl[0].s));
        check("single_busy_hi", 64'(busy0), 64'(1));
        check("lat1_latency", 64'(e1), 64'(3));
        check("lat1_data", 64'(d1), 64'(tbl[0].exp));
        check("lat1_s", 64'(s1v), 64'(tbl[0].s));
        @(negedge clk);
        check("single_rsp_drop", 64'(rsp_valid0), 64'(0));
        check("single_busy_lo", 64'(busy0), 64'(0));

        // Burst of 6 with rsp_ready held high
        next_rsp = 0;
        saw_full = 1'b0;
        push_all(0, 6);
        drain(6);
        check("burst_fifo_filled", 64'(saw_full), 64'(1));
        repeat (6) @(negedge clk);
        check("burst_idle_valid", 64'(rsp_valid0), 64'(0));
        check("burst_idle_busy", 64'(busy0), 64'(0));

        // Backpressure: response 6 held while the FIFO fills
        rsp_ready = 1'b0;
        next_rsp = 6;
        push_all(6, 5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(rsp_valid0), 64'(1));
            check("bp_data", 64'(rsp_data0), 64'(tbl[6].exp));
            check("bp_s", 64'(rsp_s0), 64'(tbl[6].s));
            check("bp_alu_a", 64'(alu_a0), 64'(tbl[6].a));
            check("bp_alu_b", 64'(alu_b0), 64'(tbl[6].b));
            check("bp_alu_s", 64'(alu_s0), 64'(tbl[6].s));
            check("bp_req_ready", 64'(req_ready0), 64'(0));
        end
        rsp_ready = 1'b1;
        collect();
        drain(11);
        repeat (3) @(negedge clk);
        check("bp_idle_busy", 64'(busy0), 64'(0));
        check("op_count_12", 64'(op_count0), OPC ? 64'(12) : 64'(0));

        // Reset while in WAIT with two entries queued
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_a = tbl[i].a;
            req_b = tbl[i].b;
            req_s = tbl[i].s;
            @(posedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_busy", 64'(busy0), 64'(1));
        check("mid_alu_a", 64'(alu_a0), 64'(tbl[0].a));
        check("mid_rsp_valid", 64'(rsp_valid0), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_rsp_valid", 64'(rsp_valid0), 64'(0));
        check("mrst_alu_a", 64'(alu_a0), 64'(0));
        check("mrst_alu_b", 64'(alu_b0), 64'(0));
        check("mrst_alu_s", 64'(alu_s0), 64'(0));
        check("mrst_req_ready", 64'(req_ready0), 64'(1));
        check("mrst_busy", 64'(busy0), 64'(0));
        check("mrst_op_count", 64'(op_count0), 64'(0));
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid0 || busy0) seen = 1'b1;
        end
        check("mrst_no_rsp", 64'(seen), 64'(0));

        // Five completions then reset for the counter
        next_rsp = 6;
        push_all(6, 5);
        drain(11);
        repeat (3) @(negedge clk);
        check("op_count_5", 64'(op_count0), OPC ? 64'(5) : 64'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("op_count_rst", 64'(op_count0), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
